fm_phase_discriminator: RTL and testbench
=========================================

Name: fm_phase_discriminator

Overview:
Consumes the phase/magnitude stream from the vectoring CORDIC and produces demodulated FM audio. Each new phase sample is differentiated against the previous one, with modulo-2^PH_BITS wrap. The phase steps are then averaged over a power-of-two window by accumulate-and-dump decimation. A magnitude squelch forces silent output when carrier strength drops below a runtime threshold.

Parameters:
PH_BITS, 32, phase word width; full circle = 2^PH_BITS, so 90° = 2^(PH_BITS-2).
MAG_BITS, 12, magnitude input and threshold width (unsigned).
OUT_BITS, 16, signed audio output width; must be <= PH_BITS.
LOG2_DECIM, 3, log2 of decimation factor; DECIM = 2^LOG2_DECIM.

Ports:
clk_in  in  1  system clock; all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
en  in  1  synchronous enable; low clears the pipeline state.
phase_in  in  PH_BITS  phase sample, two's complement, from CORDIC phase_out.
mag_in  in  MAG_BITS  modulus sample, aligned with phase_in.
phase_valid  in  1  qualifies phase_in/mag_in; one sample per high cycle, gaps allowed.
sq_thresh  in  MAG_BITS  squelch threshold, quasi-static.
audio_out  out  OUT_BITS  signed averaged phase step; full scale = ±π rad/sample.
audio_valid  out  1  one-cycle pulse per output sample.
squelched  out  1  high when the last emitted sample was squelched.

Behaviour:
- Reset (rst_n low, async): audio_out=0, audio_valid=0, squelched=0, prev_phase=0, primed=0, count=0, acc=0, low_mag=0.
- en low (sync): primed, count, acc and low_mag clear; audio_valid=0; audio_out and squelched hold.
- Stage 1 (diff), on phase_valid & en:
  - If primed=0: load prev_phase, set primed, emit no diff.
  - Else: diff = phase_in - prev_phase, PH_BITS-bit wrap, result signed; update prev_phase; diff_valid=1 next cycle.
  - The mag_in<sq_thresh flag is registered alongside diff.
- Stage 2 (accumulate/dump), on diff_valid:
  - ACC_BITS = PH_BITS+LOG2_DECIM; diff is sign-extended into acc. No overflow is possible.
  - count increments 0..DECIM-1.
  - At count=DECIM-1 (dump): audio_out = (acc+diff)[ACC_BITS-1 -: OUT_BITS], truncated with no rounding; squelched = low_mag | current flag.
  - If squelched, audio_out=0 instead.
  - audio_valid=1 for one cycle; acc, low_mag and count clear.
  - Otherwise acc += diff and low_mag |= flag.
- Latency: audio_valid is high exactly 2 clk_in cycles after the cycle carrying the DECIM-th contributing phase_valid.
- First output after reset or en rising needs DECIM+1 valid samples (1 priming + DECIM diffs).
- Gaps in phase_valid stall the counter; the window is DECIM valid samples, not cycles.
- Wrap: 0x7F000000→0x81000000 is a +0x02000000 step, not a large negative one; the ±2^(PH_BITS-1) step maps to -π.
- Async reset mid-window discards the partial window; no spurious audio_valid.
- phase_valid asserted while en low is ignored.
- Throughput: accepts phase_valid every cycle.

Decomposition:
- Shared package fm_demod_pkg holds:
  - DECIM = 1<<LOG2_DECIM;
  - ACC_BITS = PH_BITS+LOG2_DECIM;
  - OUT_SHIFT = ACC_BITS-OUT_BITS;
  - the phase-unit constant QUARTER_TURN = 2^(PH_BITS-2), shared with the CORDIC vector stage.
- One sub-module, fm_phase_diff: the priming flag, prev_phase register, wrapped subtractor and squelch-flag register. It outputs diff, diff_valid and low_flag.
- The top holds the accumulator, counter, dump and output registers.

Test Plan:
- Defaults; mag_in=0x800, sq_thresh=0x100; phase ramps +0x01000000 per valid for 9 samples → one audio_valid, audio_out=256 (0x0100), squelched=0, 2 cycles after the 9th valid.
- Ramp -0x01000000 per sample, continuous → audio_out=-256 (0xFF00) every 8 valids after priming.
- Ramp +0x02000000 starting at 0x7F000000, crossing the sign boundary → audio_out=512 on every output, no glitch.
- Same ramp as first test, one mid-window sample with mag_in=0x050 → audio_out=0, squelched=1; next window clean → 256, squelched=0.
- phase_valid every 3rd cycle, ramp +0x01000000 → outputs every 8 valids (24 cycles), value 256.
- rst_n pulsed low after 5 valids → outputs 0, no audio_valid. Re-primes and first output comes 9 valids after release. en low for 1 cycle mid-window behaves the same, with audio_out holding its prior value.

Source files
------------

// File: rtl/fm_demod_pkg.sv
// Shared constants and sizing helpers for the FM demodulator chain.
// The derived constants below describe the default build.
package fm_demod_pkg;

   localparam int PH_BITS_DEF    = 32;
   localparam int MAG_BITS_DEF   = 12;
   localparam int OUT_BITS_DEF   = 16;
   localparam int LOG2_DECIM_DEF = 3;

   localparam int DECIM     = 1 << LOG2_DECIM_DEF;
   localparam int ACC_BITS  = PH_BITS_DEF + LOG2_DECIM_DEF;
   localparam int OUT_SHIFT = ACC_BITS - OUT_BITS_DEF;

   // One quarter of a full phase circle; the CORDIC vector stage uses the same unit.
   localparam logic [PH_BITS_DEF-1:0] QUARTER_TURN = {2'b01, {(PH_BITS_DEF-2){1'b0}}};

   function automatic int acc_bits(input int ph_bits, input int log2_decim);
      return ph_bits + log2_decim;
   endfunction

endpackage

// File: rtl/fm_phase_diff.sv
// First stage: wrapped phase differentiator with a registered low-magnitude flag.
// The first valid sample after reset or enable only primes the previous-phase register.
module fm_phase_diff
   import fm_demod_pkg::*;
#(
   parameter int PH_BITS  = PH_BITS_DEF,
   parameter int MAG_BITS = MAG_BITS_DEF
) (
   input  logic                      clk_in,
   input  logic                      rst_n,
   input  logic                      en,
   input  logic [PH_BITS-1:0]        phase_in,
   input  logic [MAG_BITS-1:0]       mag_in,
   input  logic                      phase_valid,
   input  logic [MAG_BITS-1:0]       sq_thresh,
   output logic signed [PH_BITS-1:0] diff,
   output logic                      diff_valid,
   output logic                      low_flag
);

   logic               primed_reg;
   logic [PH_BITS-1:0] prev_phase_reg;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         primed_reg     <= 1'b0;
         prev_phase_reg <= '0;
         diff           <= '0;
         diff_valid     <= 1'b0;
         low_flag       <= 1'b0;
      end else if (!en) begin
         primed_reg <= 1'b0;
         diff_valid <= 1'b0;
      end else begin
         diff_valid <= 1'b0;
         if (phase_valid) begin
            prev_phase_reg <= phase_in;
            if (!primed_reg) begin
               primed_reg <= 1'b1;
            end else begin
               // Unsigned subtraction wraps modulo the full circle; reading it
               // back as signed gives the shortest step, with half-turn -> -pi.
               diff       <= phase_in - prev_phase_reg;
               diff_valid <= 1'b1;
               low_flag   <= (mag_in < sq_thresh);
            end
         end
      end
   end

endmodule

// File: rtl/fm_phase_discriminator.sv
// FM discriminator: phase differentiator followed by accumulate-and-dump
// decimation over DECIM valid steps, with magnitude squelch on each window.
module fm_phase_discriminator
   import fm_demod_pkg::*;
#(
   parameter int PH_BITS    = PH_BITS_DEF,
   parameter int MAG_BITS   = MAG_BITS_DEF,
   parameter int OUT_BITS   = OUT_BITS_DEF,
   parameter int LOG2_DECIM = LOG2_DECIM_DEF
) (
   input  logic                       clk_in,
   input  logic                       rst_n,
   input  logic                       en,
   input  logic [PH_BITS-1:0]         phase_in,
   input  logic [MAG_BITS-1:0]        mag_in,
   input  logic                       phase_valid,
   input  logic [MAG_BITS-1:0]        sq_thresh,
   output logic signed [OUT_BITS-1:0] audio_out,
   output logic                       audio_valid,
   output logic                       squelched
);

   localparam int ACC_W = acc_bits(PH_BITS, LOG2_DECIM);

   logic signed [PH_BITS-1:0] diff;
   logic                      diff_valid;
   logic                      low_flag;

   logic signed [ACC_W-1:0]   acc_reg;
   logic signed [ACC_W-1:0]   sum_next;
   logic [LOG2_DECIM-1:0]     count_reg;
   logic                      low_mag_reg;
   logic                      dump_sq_next;

   fm_phase_diff #(
      .PH_BITS  (PH_BITS),
      .MAG_BITS (MAG_BITS)
   ) u_diff (
      .clk_in      (clk_in),
      .rst_n       (rst_n),
      .en          (en),
      .phase_in    (phase_in),
      .mag_in      (mag_in),
      .phase_valid (phase_valid),
      .sq_thresh   (sq_thresh),
      .diff        (diff),
      .diff_valid  (diff_valid),
      .low_flag    (low_flag)
   );

   // LOG2_DECIM guard bits make the sum of DECIM steps overflow-free.
   always_comb begin
      sum_next     = acc_reg + {{LOG2_DECIM{diff[PH_BITS-1]}}, diff};
      dump_sq_next = low_mag_reg | low_flag;
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         acc_reg     <= '0;
         count_reg   <= '0;
         low_mag_reg <= 1'b0;
         audio_out   <= '0;
         audio_valid <= 1'b0;
         squelched   <= 1'b0;
      end else if (!en) begin
         acc_reg     <= '0;
         count_reg   <= '0;
         low_mag_reg <= 1'b0;
         audio_valid <= 1'b0;
      end else begin
         audio_valid <= 1'b0;
         if (diff_valid) begin
            if (count_reg == '1) begin
               audio_out   <= dump_sq_next ? '0 : sum_next[ACC_W-1 -: OUT_BITS];
               squelched   <= dump_sq_next;
               audio_valid <= 1'b1;
               acc_reg     <= '0;
               count_reg   <= '0;
               low_mag_reg <= 1'b0;
            end else begin
               acc_reg     <= sum_next;
               count_reg   <= count_reg + LOG2_DECIM'(1);
               low_mag_reg <= dump_sq_next;
            end
         end
      end
   end

endmodule

// File: tb/tb_fm_phase_discriminator.sv
// Directed plus randomized bench for fm_phase_discriminator, checked against
// a window-averaging model of the demodulator.
module tb_fm_phase_discriminator;

   logic        clk_in = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic [31:0] phase_in = '0;
   logic [11:0] mag_in = '0;
   logic        phase_valid = 1'b0;
   logic [11:0] sq_thresh = 12'h100;
   logic [15:0] audio_out;
   logic        audio_valid;
   logic        squelched;

   fm_phase_discriminator dut (
      .clk_in      (clk_in),
      .rst_n       (rst_n),
      .en          (en),
      .phase_in    (phase_in),
      .mag_in      (mag_in),
      .phase_valid (phase_valid),
      .sq_thresh   (sq_thresh),
      .audio_out   (audio_out),
      .audio_valid (audio_valid),
      .squelched   (squelched)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      int          due;
      logic [15:0] val;
      logic        sq;
   } ev_t;

   ev_t         exp_q[$];
   int          n = 0;
   int          checks = 0;
   int          failures = 0;

   // Model state: window contents summarised as a running sum of wrapped steps.
   bit          m_primed = 0;
   logic [31:0] m_prev = '0;
   longint      m_sum = 0;
   int          m_cnt = 0;
   bit          m_low = 0;
   logic [15:0] last_out = '0;
   logic        last_sq = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, n, obs, expv);
      end
   endtask

   task automatic model_clear(input bit full);
      m_primed = 0;
      m_sum    = 0;
      m_cnt    = 0;
      m_low    = 0;
      exp_q.delete();
      if (full) begin
         m_prev   = '0;
         last_out = '0;
         last_sq  = 1'b0;
      end
   endtask

   task automatic model_sample(input logic [31:0] ph, input logic [11:0] mg);
      logic [31:0] d;
      logic [15:0] v;
      if (!m_primed) begin
         m_prev   = ph;
         m_primed = 1;
      end else begin
         d      = ph - m_prev;
         m_prev = ph;
         m_sum  = m_sum + longint'($signed(d));
         m_low  = m_low | (mg < sq_thresh);
         m_cnt++;
         if (m_cnt == 8) begin
            v = m_low ? 16'h0000 : 16'(m_sum >>> 19);
            exp_q.push_back('{due: n + 2, val: v, sq: m_low});
            m_sum = 0;
            m_cnt = 0;
            m_low = 0;
         end
      end
   endtask

   // Observe outputs on the falling edge, then drive the next cycle's inputs.
   task automatic step(input logic r, input logic e, input logic v,
                       input logic [31:0] ph, input logic [11:0] mg);
      logic exp_av;
      @(negedge clk_in);
      n++;
      exp_av = (exp_q.size() > 0) && (exp_q[0].due == n);
      check("audio_valid", {31'b0, audio_valid}, {31'b0, exp_av});
      if (exp_av) begin
         last_out = exp_q[0].val;
         last_sq  = exp_q[0].sq;
         void'(exp_q.pop_front());
      end
      check("audio_out", {16'b0, audio_out}, {16'b0, last_out});
      check("squelched", {31'b0, squelched}, {31'b0, last_sq});
      rst_n       = r;
      en          = e;
      phase_valid = v;
      phase_in    = ph;
      mag_in      = mg;
      if (!r)
         model_clear(1);
      else if (!e)
         model_clear(0);
      else if (v)
         model_sample(ph, mg);
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++)
         step(1, 1, 0, $urandom, 12'h800);
   endtask

   task automatic ramp(input logic [31:0] start, input logic [31:0] inc,
                       input int nsamp, input int gap, input int sq_idx);
      logic [31:0] ph;
      ph = start;
      for (int i = 0; i < nsamp; i++) begin
         step(1, 1, 1, ph, (i == sq_idx) ? 12'h050 : 12'h800);
         ph = ph + inc;
         if (i != nsamp - 1)
            for (int g = 0; g < gap; g++)
               step(1, 1, 0, $urandom, 12'h800);
      end
   endtask

   task automatic en_low_pulse();
      step(1, 0, 1, $urandom, 12'h800);
   endtask

   initial begin
      // Reset state
      for (int i = 0; i < 3; i++)
         step(0, 0, 0, '0, '0);
      check("reset_audio_out", {16'b0, audio_out}, 32'h0);
      check("reset_audio_valid", {31'b0, audio_valid}, 32'h0);
      check("reset_squelched", {31'b0, squelched}, 32'h0);

      // Positive ramp, single window
      ramp(32'h0000_0000, 32'h0100_0000, 9, 0, -1);
      idle(3);
      check("ramp_pos", {16'b0, audio_out}, 32'h0100);

      // Negative ramp, continuous, three windows
      en_low_pulse();
      ramp(32'h1000_0000, 32'hFF00_0000, 25, 0, -1);
      idle(3);
      check("ramp_neg", {16'b0, audio_out}, 32'hFF00);

      // Crossing the sign boundary
      en_low_pulse();
      ramp(32'h7F00_0000, 32'h0200_0000, 17, 0, -1);
      idle(3);
      check("ramp_wrap", {16'b0, audio_out}, 32'h0200);

      // Squelched window, then a clean one
      en_low_pulse();
      ramp(32'h0000_0000, 32'h0100_0000, 9, 0, 4);
      idle(3);
      check("sq_value", {16'b0, audio_out}, 32'h0000);
      check("sq_flag", {31'b0, squelched}, 32'h1);
      ramp(32'h0900_0000, 32'h0100_0000, 8, 0, -1);
      idle(3);
      check("sq_clean_value", {16'b0, audio_out}, 32'h0100);
      check("sq_clean_flag", {31'b0, squelched}, 32'h0);

      // Sparse valids: every third cycle
      en_low_pulse();
      ramp(32'h0000_0000, 32'h0100_0000, 17, 2, -1);
      idle(3);
      check("sparse", {16'b0, audio_out}, 32'h0100);

      // Async reset mid-window
      en_low_pulse();
      ramp(32'h0000_0000, 32'h0100_0000, 5, 0, -1);
      step(0, 1, 1, 32'h0500_0000, 12'h800);
      step(0, 1, 0, '0, 12'h800);
      check("midreset_out", {16'b0, audio_out}, 32'h0);
      ramp(32'h0000_0000, 32'h0100_0000, 9, 0, -1);
      idle(3);
      check("after_reset", {16'b0, audio_out}, 32'h0100);

      // Enable dropped mid-window: output holds, window restarts
      en_low_pulse();
      ramp(32'h3000_0000, 32'hFF00_0000, 9, 0, -1);
      idle(3);
      ramp(32'h0000_0000, 32'h0100_0000, 5, 0, -1);
      en_low_pulse();
      idle(2);
      check("enlow_hold", {16'b0, audio_out}, 32'hFF00);
      ramp(32'h4000_0000, 32'h0100_0000, 9, 0, -1);
      idle(3);
      check("after_enlow", {16'b0, audio_out}, 32'h0100);

      // Half-turn steps map to -pi
      en_low_pulse();
      ramp(32'h0000_0000, 32'h8000_0000, 9, 0, -1);
      idle(3);
      check("half_turn", {16'b0, audio_out}, 32'h8000);

      // Randomized traffic
      for (int i = 0; i < 800; i++)
         step(1, ($urandom_range(0, 59) != 0), ($urandom_range(0, 2) != 0),
              $urandom, 12'($urandom_range(0, 12'h7FF)));
      idle(4);
      check("queue_drained", exp_q.size(), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
